// File: rtl/mod_counter_sequencer.sv
// Sequencer for a modulo-N counter: run request, wrap budget, pause, abort and done pulse.
// Build option MODSEQ_UPDOWN_EN adds a dir input that selects down-counting.
module mod_counter_sequencer #(
  parameter int WIDTH       = 3,
  parameter int MOD_DEFAULT = 5,
  parameter int CYC_W       = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_last,
  input  logic [CYC_W-1:0] cycles,
  input  logic             pause,
  input  logic             stop,
`ifdef MODSEQ_UPDOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             wrap,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  // Handshake: start is a request taken only in IDLE (busy high means not ready);
  // pause is a level honoured in RUN/HOLD, stop an abort that outranks pause.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] LAST_DEFAULT = WIDTH'(MOD_DEFAULT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_d, last_q, last_d, last_sel;
  logic [CYC_W-1:0] cyc_q, cyc_d, wcnt_q, wcnt_d, wcnt_inc;
  logic             wrap_d, down_q, at_end;

`ifdef MODSEQ_UPDOWN_EN
  logic down_d;
`else
  assign down_q = 1'b0;
`endif

  assign last_sel = (cfg_last == '0) ? LAST_DEFAULT : cfg_last;
  // Wrap counter saturates so continuous runs never roll it over.
  assign wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + CYC_W'(1);
  assign at_end   = down_q ? (Q == '0) : (Q == last_q);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      Q       <= '0;
      wrap    <= 1'b0;
      last_q  <= LAST_DEFAULT;
      cyc_q   <= '0;
      wcnt_q  <= '0;
`ifdef MODSEQ_UPDOWN_EN
      down_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      Q       <= q_d;
      wrap    <= wrap_d;
      last_q  <= last_d;
      cyc_q   <= cyc_d;
      wcnt_q  <= wcnt_d;
`ifdef MODSEQ_UPDOWN_EN
      down_q  <= down_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = Q;
    wrap_d  = 1'b0;
    last_d  = last_q;
    cyc_d   = cyc_q;
    wcnt_d  = wcnt_q;
`ifdef MODSEQ_UPDOWN_EN
    down_d  = down_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          last_d  = last_sel;
          cyc_d   = cycles;
          wcnt_d  = '0;
          q_d     = '0;
`ifdef MODSEQ_UPDOWN_EN
          down_d  = dir;
          if (dir) q_d = last_sel;
`endif
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          q_d     = '0;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (at_end) begin
          q_d    = down_q ? last_q : '0;
          wrap_d = 1'b1;
          wcnt_d = wcnt_inc;
          if ((cyc_q != '0) && (wcnt_inc == cyc_q)) begin
            state_d = ST_DONE;
            q_d     = '0;
          end
        end else begin
          q_d = down_q ? (Q - WIDTH'(1)) : (Q + WIDTH'(1));
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
          q_d     = '0;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        q_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        q_d     = '0;
      end
    endcase
  end

  assign state = state_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done  = (state_q == ST_DONE);

endmodule
